// File: rtl/rf_pkg.sv
// Shared constants and scan state encoding for the 2R1W register file.
// Imported by regfile_2r1w and rf_dbg_scan.
package rf_pkg;

    localparam int WIDTH    = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/rf_dbg_scan.sv
// Debug scan engine: streams every register out over valid/ready.
// Ports: clk/rst, req, ready, write bus (wr_en/wr_idx/wr_data) for
// same-edge capture, peek_idx/peek_data array read, valid/idx/data/busy.
module rf_dbg_scan
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [ADDR_W-1:0] peek_idx,
    input  logic [WIDTH-1:0]  peek_data,
    output logic              valid,
    output logic [ADDR_W-1:0] idx,
    output logic [WIDTH-1:0]  data,
    output logic              busy
);

    scan_state_t       state, state_nxt;
    logic [ADDR_W-1:0] idx_q, idx_nxt;
    logic [WIDTH-1:0]  data_q, data_nxt;
    logic [WIDTH-1:0]  fresh;

    assign peek_idx = idx_q + ADDR_W'(1);

    // Next beat must reflect a write landing on the same edge.
    assign fresh = (wr_en && wr_idx == peek_idx && wr_idx != '0)
                   ? wr_data : peek_data;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        data_nxt  = data_q;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                    data_nxt  = '0;
                end
            end
            SCAN: begin
                if (ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt  = peek_idx;
                        data_nxt = fresh;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            idx_q  <= idx_nxt;
            data_q <= data_nxt;
        end
    end

    assign valid = (state == SCAN);
    assign busy  = (state == SCAN);
    assign idx   = idx_q;
    assign data  = data_q;

endmodule

// File: rtl/regfile_2r1w.sv
// 32x32 register file, 2 async reads, 1 sync write, r0 hard-wired to 0,
// plus a debug scan port. Ports: Clk, Rst (sync, active-high),
// Rna/Rnb -> Qa/Qb, We/Wn/D write, Dbg_Req/Dbg_Ready in,
// Dbg_Valid/Dbg_Idx/Dbg_Data/Dbg_Busy out.
// Option RF_BYPASS_EN: write-through of D onto matching reads
// (pipelined use only; forms a loop in the single-cycle core).
module regfile_2r1w
    import rf_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Rna,
    input  logic [ADDR_W-1:0] Rnb,
    output logic [WIDTH-1:0]  Qa,
    output logic [WIDTH-1:0]  Qb,
    input  logic              We,
    input  logic [ADDR_W-1:0] Wn,
    input  logic [WIDTH-1:0]  D,
    input  logic              Dbg_Req,
    input  logic              Dbg_Ready,
    output logic              Dbg_Valid,
    output logic [ADDR_W-1:0] Dbg_Idx,
    output logic [WIDTH-1:0]  Dbg_Data,
    output logic              Dbg_Busy
);

    logic [WIDTH-1:0]  regs [NUM_REGS];
    logic [WIDTH-1:0]  stored_a, stored_b;
    logic [ADDR_W-1:0] peek_idx;
    logic [WIDTH-1:0]  peek_data;
    logic              wr_ok;

    assign wr_ok = We && (Wn != '0);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[Wn] <= D;
        end
    end

    assign stored_a  = (Rna == '0) ? '0 : regs[Rna];
    assign stored_b  = (Rnb == '0) ? '0 : regs[Rnb];
    assign peek_data = (peek_idx == '0) ? '0 : regs[peek_idx];

`ifdef RF_BYPASS_EN
    assign Qa = (wr_ok && Wn == Rna) ? D : stored_a;
    assign Qb = (wr_ok && Wn == Rnb) ? D : stored_b;
`else
    assign Qa = stored_a;
    assign Qb = stored_b;
`endif

    rf_dbg_scan u_scan (
        .clk       (Clk),
        .rst       (Rst),
        .req       (Dbg_Req),
        .ready     (Dbg_Ready),
        .wr_en     (We),
        .wr_idx    (Wn),
        .wr_data   (D),
        .peek_idx  (peek_idx),
        .peek_data (peek_data),
        .valid     (Dbg_Valid),
        .idx       (Dbg_Idx),
        .data      (Dbg_Data),
        .busy      (Dbg_Busy)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed plus random stimulus
// against an array/scoreboard reference model.
module tb_regfile_2r1w;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [4:0]  Rna = '0;
    logic [4:0]  Rnb = '0;
    logic [31:0] Qa;
    logic [31:0] Qb;
    logic        We = 1'b0;
    logic [4:0]  Wn = '0;
    logic [31:0] D = '0;
    logic        Dbg_Req = 1'b0;
    logic        Dbg_Ready = 1'b0;
    logic        Dbg_Valid;
    logic [4:0]  Dbg_Idx;
    logic [31:0] Dbg_Data;
    logic        Dbg_Busy;

    int checks = 0;
    int errors = 0;
    int dut_beats = 0;

    // Reference model
    logic [31:0] ref_rf [32];
    bit          m_scan = 0;
    int          m_idx = 0;
    logic [31:0] m_snap = '0;

    always #5 Clk = ~Clk;

    regfile_2r1w dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Rna       (Rna),
        .Rnb       (Rnb),
        .Qa        (Qa),
        .Qb        (Qb),
        .We        (We),
        .Wn        (Wn),
        .D         (D),
        .Dbg_Req   (Dbg_Req),
        .Dbg_Ready (Dbg_Ready),
        .Dbg_Valid (Dbg_Valid),
        .Dbg_Idx   (Dbg_Idx),
        .Dbg_Data  (Dbg_Data),
        .Dbg_Busy  (Dbg_Busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int n);
        if (n == 0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (We && Wn != 0 && int'(Wn) == n) return D;
`endif
        return ref_rf[n];
    endfunction

    task automatic check_reads(input string tag);
        #1;
        check({tag, "_qa"}, Qa, exp_rd(int'(Rna)));
        check({tag, "_qb"}, Qb, exp_rd(int'(Rnb)));
    endtask

    // Advance one clock: update model with the inputs seen at the edge,
    // then compare the scan outputs just after the edge.
    task automatic tick();
        if (Dbg_Valid && Dbg_Ready) dut_beats++;
        if (Rst) begin
            foreach (ref_rf[i]) ref_rf[i] = '0;
            m_scan = 0;
            m_idx  = 0;
            m_snap = '0;
        end else begin
            if (We && Wn != 0) ref_rf[Wn] = D;
            if (!m_scan) begin
                if (Dbg_Req) begin
                    m_scan = 1;
                    m_idx  = 0;
                    m_snap = '0;
                end
            end else if (Dbg_Ready) begin
                if (m_idx == 31) begin
                    m_scan = 0;
                    m_idx  = 0;
                end else begin
                    m_idx  = m_idx + 1;
                    m_snap = ref_rf[m_idx];
                end
            end
        end
        @(posedge Clk);
        #1;
        check("valid", {31'b0, Dbg_Valid}, {31'b0, m_scan});
        check("busy", {31'b0, Dbg_Busy}, {31'b0, m_scan});
        check("idx", {27'b0, Dbg_Idx}, 32'(m_idx));
        if (m_scan) check("data", Dbg_Data, m_snap);
    endtask

    task automatic run_until_idx(input int k);
        for (int i = 0; i < 40 && m_idx != k && m_scan; i++) tick();
    endtask

    task automatic run_scan();
        for (int i = 0; i < 40 && m_scan; i++) tick();
        check("scan_done_busy", {31'b0, Dbg_Busy}, 32'h0);
    endtask

    initial begin
        foreach (ref_rf[i]) ref_rf[i] = 'x;

        // Reset, then all reads zero
        Rst = 1;
        tick();
        Rst = 0;
        check("rst_data", Dbg_Data, 32'h0);
        for (int i = 0; i < 32; i++) begin
            Rna = 5'(i);
            Rnb = 5'(31 - i);
            check_reads("rst_rd");
        end

        // Basic write and r0 protection
        We = 1; Wn = 5; D = 32'hDEADBEEF;
        tick();
        We = 0; Rna = 5; Rnb = 5;
        check_reads("r5");
        check("r5_const", Qa, 32'hDEADBEEF);
        We = 1; Wn = 0; D = 32'h1234;
        tick();
        We = 0; Rna = 0;
        check_reads("r0");
        check("r0_const", Qa, 32'h0);

        // Same-cycle read of the register being written
        We = 1; Wn = 7; D = 32'hA5A5A5A5; Rna = 7; Rnb = 7;
        check_reads("wr_same");
`ifdef RF_BYPASS_EN
        check("bypass_const", Qa, 32'hA5A5A5A5);
`else
        check("nobypass_const", Qa, 32'h0);
`endif
        tick();
        We = 0;
        check_reads("wr_next");
        check("wr_next_const", Qa, 32'hA5A5A5A5);

        // Load rk = k*0x01010101 and do a full scan with Ready tied high
        for (int k = 1; k < 32; k++) begin
            We = 1; Wn = 5'(k); D = 32'(k) * 32'h01010101;
            tick();
        end
        We = 0;
        dut_beats = 0;
        Dbg_Ready = 1; Dbg_Req = 1;
        tick();
        Dbg_Req = 0;
        check("scan_first_data", Dbg_Data, 32'h0);
        run_scan();
        check("scan_beats", 32'(dut_beats), 32'd32);

        // Stall at idx 3, overwrite r3, then same-edge write into r4
        Dbg_Req = 1; Dbg_Ready = 0;
        tick();
        Dbg_Req = 0; Dbg_Ready = 1;
        run_until_idx(3);
        Dbg_Ready = 0; We = 1; Wn = 3; D = 32'hFFFFFFFF;
        tick();
        check("stall_idx", {27'b0, Dbg_Idx}, 32'd3);
        check("stall_data", Dbg_Data, 32'h03030303);
        Dbg_Ready = 1; We = 1; Wn = 4; D = 32'h44;
        tick();
        We = 0;
        check("same_edge_data", Dbg_Data, 32'h44);
        run_scan();

        // Reset in the middle of a scan
        Dbg_Req = 1;
        tick();
        Dbg_Req = 0;
        run_until_idx(10);
        check("pre_rst_idx", {27'b0, Dbg_Idx}, 32'd10);
        Rst = 1;
        tick();
        Rst = 0;
        check("mid_rst_valid", {31'b0, Dbg_Valid}, 32'h0);
        check("mid_rst_data", Dbg_Data, 32'h0);
        for (int i = 0; i < 32; i++) begin
            Rna = 5'(i);
            Rnb = 5'(i);
            check_reads("mid_rst_rd");
        end
        tick();

        // Second request during a scan is ignored
        dut_beats = 0;
        Dbg_Req = 1;
        tick();
        Dbg_Req = 0;
        run_until_idx(5);
        Dbg_Req = 1;
        tick();
        Dbg_Req = 0;
        run_scan();
        for (int i = 0; i < 3; i++) tick();
        check("req_ignored_beats", 32'(dut_beats), 32'd32);

        // Random traffic on all ports
        for (int i = 0; i < 400; i++) begin
            We        = ($urandom_range(0, 1) == 1);
            Wn        = 5'($urandom_range(0, 31));
            D         = $urandom;
            Rna       = 5'($urandom_range(0, 31));
            Rnb       = 5'($urandom_range(0, 31));
            Dbg_Ready = ($urandom_range(0, 1) == 1);
            Dbg_Req   = ($urandom_range(0, 19) == 0);
            check_reads("rnd");
            tick();
        end
        We = 0; Dbg_Req = 0; Dbg_Ready = 1;
        run_scan();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
